// File: rtl/u_mem_master_arbiter_if.sv
// rtl/u_mem_master_arbiter_if.sv - Avalon-MM style u_mem port bundle shared by both masters and the slave side
interface u_mem_master_arbiter_if #(
  parameter int ADDR_WIDTH  = 29,
  parameter int DATA_WIDTH  = 512,
  parameter int BURST_WIDTH = 7
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [BURST_WIDTH-1:0]  burstcount;
  logic                    waitrequest;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable, burstcount,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable, burstcount,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/u_mem_master_arbiter.sv
// rtl/u_mem_master_arbiter.sv - burst-aware 2:1 u_mem arbiter with in-order read response routing
// Optional build macro U_MEM_ARB_FIXED_PRIO_EN: m0 always wins ties instead of round robin.
module u_mem_master_arbiter #(
  parameter int ADDR_WIDTH     = 29,
  parameter int DATA_WIDTH     = 512,
  parameter int BURST_WIDTH    = 7,
  parameter int RSP_FIFO_DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  u_mem_master_arbiter_if.slave   m0,
  u_mem_master_arbiter_if.slave   m1,
  u_mem_master_arbiter_if.master  s
);
  localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);

  typedef enum logic {IDLE, WR_LOCK} state_t;

  state_t                  state_q, state_d;
`ifndef U_MEM_ARB_FIXED_PRIO_EN
  logic                    last_grant_q;
`endif
  logic                    wr_owner_q;
  logic [BURST_WIDTH-1:0]  wr_left_q;
  logic [BURST_WIDTH-1:0]  rd_cnt_q;
  logic [BURST_WIDTH:0]    fifo_mem [RSP_FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]          fifo_cnt_q;

  logic                    fifo_full, fifo_empty, head_owner, head_last;
  logic [BURST_WIDTH-1:0]  head_bc;
  logic                    req0, req1, gnt, gnt_valid;
  logic [ADDR_WIDTH-1:0]   sel_address;
  logic [DATA_WIDTH-1:0]   sel_writedata;
  logic [DATA_WIDTH/8-1:0] sel_byteenable;
  logic [BURST_WIDTH-1:0]  sel_burstcount;
  logic                    sel_read, sel_write;
  logic                    s_read_c, s_write_c, accept, push, pop, rsp_beat;

  assign fifo_full  = (fifo_cnt_q == (PTR_W+1)'(RSP_FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign {head_owner, head_bc} = fifo_mem[rd_ptr_q];
  assign head_last  = (rd_cnt_q == head_bc - BURST_WIDTH'(1));

  // A read blocked by a full owner FIFO does not count as a request, so the other master's write can win.
  assign req0 = m0.write | (m0.read & ~fifo_full);
  assign req1 = m1.write | (m1.read & ~fifo_full);

  always_comb begin
    state_d   = state_q;
    gnt       = 1'b0;
    gnt_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
`ifdef U_MEM_ARB_FIXED_PRIO_EN
          gnt = 1'b0;
`else
          gnt = ~last_grant_q;
`endif
          gnt_valid = 1'b1;
        end else if (req0) begin
          gnt_valid = 1'b1;
        end else if (req1) begin
          gnt       = 1'b1;
          gnt_valid = 1'b1;
        end
      end
      WR_LOCK: begin
        gnt       = wr_owner_q;
        gnt_valid = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (reset) gnt_valid = 1'b0;

    sel_address    = gnt ? m1.address    : m0.address;
    sel_writedata  = gnt ? m1.writedata  : m0.writedata;
    sel_byteenable = gnt ? m1.byteenable : m0.byteenable;
    sel_burstcount = gnt ? m1.burstcount : m0.burstcount;
    sel_read       = gnt ? m1.read       : m0.read;
    sel_write      = gnt ? m1.write      : m0.write;

    // Reads are never passed in WR_LOCK: the owner reading mid-burst is illegal and other masters are locked out.
    s_read_c  = gnt_valid & (state_q == IDLE) & sel_read & ~fifo_full;
    s_write_c = gnt_valid & sel_write;
    accept    = (s_read_c | s_write_c) & ~s.waitrequest;

    if (accept && s_write_c) begin
      if (state_q == IDLE && sel_burstcount > BURST_WIDTH'(1)) state_d = WR_LOCK;
      if (state_q == WR_LOCK && wr_left_q == BURST_WIDTH'(1))  state_d = IDLE;
    end
  end

  assign push     = s_read_c & ~s.waitrequest;
  assign rsp_beat = s.readdatavalid & ~fifo_empty;
  assign pop      = rsp_beat & head_last;

  assign s.address    = sel_address;
  assign s.writedata  = sel_writedata;
  assign s.byteenable = sel_byteenable;
  assign s.burstcount = sel_burstcount;
  assign s.read       = s_read_c;
  assign s.write      = s_write_c;

  assign m0.waitrequest   = reset | ~(gnt_valid & ~gnt & (s_read_c | s_write_c)) | s.waitrequest;
  assign m1.waitrequest   = reset | ~(gnt_valid &  gnt & (s_read_c | s_write_c)) | s.waitrequest;
  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;
  assign m0.readdatavalid = ~reset & rsp_beat & ~head_owner;
  assign m1.readdatavalid = ~reset & rsp_beat &  head_owner;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
`ifndef U_MEM_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
      wr_owner_q   <= 1'b0;
      wr_left_q    <= '0;
      rd_cnt_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept && state_q == IDLE) begin
`ifndef U_MEM_ARB_FIXED_PRIO_EN
        last_grant_q <= gnt;
`endif
        if (s_write_c) begin
          wr_owner_q <= gnt;
          wr_left_q  <= sel_burstcount - BURST_WIDTH'(1);
        end
      end else if (accept && state_q == WR_LOCK) begin
        wr_left_q <= wr_left_q - BURST_WIDTH'(1);
      end
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + (PTR_W+1)'(1);
      else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - (PTR_W+1)'(1);
      if (rsp_beat) rd_cnt_q <= head_last ? '0 : rd_cnt_q + BURST_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {gnt, sel_burstcount};
  end

  a_lock_read: assert property (@(posedge clk) disable iff (reset)
    !(state_q == WR_LOCK && (wr_owner_q ? m1.read : m0.read)));
  a_rsp_empty: assert property (@(posedge clk) disable iff (reset)
    !(s.readdatavalid && fifo_empty));
  a_bc_zero: assert property (@(posedge clk) disable iff (reset)
    !(accept && state_q == IDLE && sel_burstcount == '0));
endmodule

// File: tb/tb_u_mem_master_arbiter.sv
// tb/tb_u_mem_master_arbiter.sv - directed self-checking bench for u_mem_master_arbiter
module tb_u_mem_master_arbiter;
  localparam int AW = 29;
  localparam int DW = 512;
  localparam int BW = 7;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [9:0] stall_pat;
  int   beat;

  always #5 clk = ~clk;

  u_mem_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) m0_bus ();
  u_mem_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) m1_bus ();
  u_mem_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) s_bus ();

  u_mem_master_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW), .RSP_FIFO_DEPTH(64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_bus.read = 1'b0; m0_bus.write = 1'b0; m0_bus.address = '0;
    m0_bus.writedata = '0; m0_bus.byteenable = '1; m0_bus.burstcount = BW'(1);
    m1_bus.read = 1'b0; m1_bus.write = 1'b0; m1_bus.address = '0;
    m1_bus.writedata = '0; m1_bus.byteenable = '1; m1_bus.burstcount = BW'(1);
    s_bus.waitrequest = 1'b0; s_bus.readdatavalid = 1'b0; s_bus.readdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    // reset state, with requests and a stray response present
    reset = 1'b1;
    idle_inputs();
    m0_bus.read = 1'b1;
    m1_bus.write = 1'b1;
    s_bus.readdatavalid = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk1("rst_m0_wait", m0_bus.waitrequest, 1'b1);
    chk1("rst_m1_wait", m1_bus.waitrequest, 1'b1);
    chk1("rst_s_read", s_bus.read, 1'b0);
    chk1("rst_s_write", s_bus.write, 1'b0);
    chk1("rst_m0_rdv", m0_bus.readdatavalid, 1'b0);
    chk1("rst_m1_rdv", m1_bus.readdatavalid, 1'b0);
    idle_inputs();
    reset = 1'b0;
    next_cycle();

    // single m0 read burst of 4, slave latency 5
    m0_bus.read = 1'b1; m0_bus.address = AW'('h100); m0_bus.burstcount = BW'(4);
    #1;
    chk1("t1_s_read", s_bus.read, 1'b1);
    chkv("t1_s_addr", 64'(s_bus.address), 64'h100);
    chkv("t1_s_bc", 64'(s_bus.burstcount), 64'd4);
    chk1("t1_m0_wait", m0_bus.waitrequest, 1'b0);
    chk1("t1_m1_wait", m1_bus.waitrequest, 1'b1);
    next_cycle();
    m0_bus.read = 1'b0;
    repeat (4) next_cycle();
    for (int i = 0; i < 4; i++) begin
      s_bus.readdatavalid = 1'b1;
      s_bus.readdata = DW'(64'hA0 + 64'(i));
      #1;
      chk1("t1_m0_rdv", m0_bus.readdatavalid, 1'b1);
      chk1("t1_m1_rdv", m1_bus.readdatavalid, 1'b0);
      chkv("t1_m0_rdata", m0_bus.readdata[63:0], 64'hA0 + 64'(i));
      next_cycle();
    end
    s_bus.readdatavalid = 1'b0;

    // both masters read every cycle: round robin starting with m0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m0_bus.read = 1'b1; m0_bus.address = AW'('h200); m0_bus.burstcount = BW'(1);
      m1_bus.read = 1'b1; m1_bus.address = AW'('h300); m1_bus.burstcount = BW'(1);
      #1;
      chkv("t2_s_addr", 64'(s_bus.address), (i % 2 == 1) ? 64'h300 : 64'h200);
      chk1("t2_m0_wait", m0_bus.waitrequest, (i % 2 == 1));
      chk1("t2_m1_wait", m1_bus.waitrequest, (i % 2 == 0));
      next_cycle();
    end
    m0_bus.read = 1'b0; m1_bus.read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_bus.readdatavalid = 1'b1;
      #1;
      chk1("t2_m0_rdv", m0_bus.readdatavalid, (i % 2 == 0));
      chk1("t2_m1_rdv", m1_bus.readdatavalid, (i % 2 == 1));
      next_cycle();
    end
    s_bus.readdatavalid = 1'b0;

    // m1 write burst of 8 with slave stalls, m0 read waits until after the last beat
    do_reset();
    stall_pat = 10'b00_0010_0100;
    beat = 1;
    for (int c = 0; c < 10; c++) begin
      m1_bus.write = 1'b1; m1_bus.address = AW'('h400); m1_bus.burstcount = BW'(8);
      m1_bus.writedata = DW'(beat);
      m0_bus.read = (c > 0); m0_bus.address = AW'('h500); m0_bus.burstcount = BW'(1);
      s_bus.waitrequest = stall_pat[c];
      #1;
      chk1("t3_s_write", s_bus.write, 1'b1);
      chkv("t3_s_wdata", s_bus.writedata[63:0], 64'(beat));
      chk1("t3_m0_wait", m0_bus.waitrequest, 1'b1);
      chk1("t3_m1_wait", m1_bus.waitrequest, stall_pat[c]);
      next_cycle();
      if (!stall_pat[c]) beat++;
    end
    m1_bus.write = 1'b0;
    s_bus.waitrequest = 1'b0;
    #1;
    chk1("t3_after_s_read", s_bus.read, 1'b1);
    chk1("t3_after_s_write", s_bus.write, 1'b0);
    chkv("t3_after_addr", 64'(s_bus.address), 64'h500);
    chk1("t3_after_m0_wait", m0_bus.waitrequest, 1'b0);
    next_cycle();
    m0_bus.read = 1'b0;
    s_bus.readdatavalid = 1'b1;
    #1;
    chk1("t3_m0_rdv", m0_bus.readdatavalid, 1'b1);
    next_cycle();
    s_bus.readdatavalid = 1'b0;

    // reset during beat 3 of a write burst, with an m1 read still outstanding
    do_reset();
    m1_bus.read = 1'b1; m1_bus.address = AW'('h600); m1_bus.burstcount = BW'(1);
    #1;
    chk1("t5_m1_rd_wait", m1_bus.waitrequest, 1'b0);
    next_cycle();
    m1_bus.read = 1'b0;
    for (int b = 1; b <= 2; b++) begin
      m1_bus.write = 1'b1; m1_bus.burstcount = BW'(8); m1_bus.writedata = DW'(b);
      #1;
      chk1("t5_m1_wr_wait", m1_bus.waitrequest, 1'b0);
      next_cycle();
    end
    m1_bus.writedata = DW'(3);
    reset = 1'b1;
    #1;
    chk1("t5_rst_m0_wait", m0_bus.waitrequest, 1'b1);
    chk1("t5_rst_m1_wait", m1_bus.waitrequest, 1'b1);
    chk1("t5_rst_s_write", s_bus.write, 1'b0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    m0_bus.read = 1'b1; m0_bus.address = AW'('h700); m0_bus.burstcount = BW'(1);
    #1;
    chk1("t5_idle_s_read", s_bus.read, 1'b1);
    chk1("t5_idle_m0_wait", m0_bus.waitrequest, 1'b0);
    next_cycle();
    m0_bus.read = 1'b0;
    s_bus.readdatavalid = 1'b1;
    #1;
    chk1("t5_fifo_m0_rdv", m0_bus.readdatavalid, 1'b1);
    chk1("t5_fifo_m1_rdv", m1_bus.readdatavalid, 1'b0);
    next_cycle();
    s_bus.readdatavalid = 1'b0;

    // fill the owner FIFO with 64 reads, responses held off
    do_reset();
    for (int i = 0; i < 64; i++) begin
      m0_bus.read = 1'b1; m0_bus.address = AW'(i); m0_bus.burstcount = BW'(1);
      #1;
      chk1("t4_fill_m0_wait", m0_bus.waitrequest, 1'b0);
      next_cycle();
    end
    m1_bus.write = 1'b1; m1_bus.address = AW'('h800); m1_bus.burstcount = BW'(1);
    #1;
    chk1("t4_full_m0_wait", m0_bus.waitrequest, 1'b1);
    chk1("t4_full_s_read", s_bus.read, 1'b0);
    chk1("t4_full_s_write", s_bus.write, 1'b1);
    chk1("t4_full_m1_wait", m1_bus.waitrequest, 1'b0);
    next_cycle();
    m1_bus.write = 1'b0;
    s_bus.readdatavalid = 1'b1;
    #1;
    chk1("t4_pop_m0_wait", m0_bus.waitrequest, 1'b1);
    chk1("t4_pop_m0_rdv", m0_bus.readdatavalid, 1'b1);
    next_cycle();
    s_bus.readdatavalid = 1'b0;
    #1;
    chk1("t4_next_m0_wait", m0_bus.waitrequest, 1'b0);
    chk1("t4_next_s_read", s_bus.read, 1'b1);
    next_cycle();

    // bring the FIFO to 63, then push (m1) and pop in the same cycle
    m0_bus.read = 1'b0;
    s_bus.readdatavalid = 1'b1;
    #1;
    chk1("t6_pop_m0_rdv", m0_bus.readdatavalid, 1'b1);
    next_cycle();
    m1_bus.read = 1'b1; m1_bus.address = AW'('h900); m1_bus.burstcount = BW'(1);
    #1;
    chk1("t6_pp_m1_wait", m1_bus.waitrequest, 1'b0);
    chk1("t6_pp_s_read", s_bus.read, 1'b1);
    chk1("t6_pp_m0_rdv", m0_bus.readdatavalid, 1'b1);
    next_cycle();
    m1_bus.read = 1'b0;
    s_bus.readdatavalid = 1'b0;
    m0_bus.read = 1'b1;
    #1;
    chk1("t6_63_m0_wait", m0_bus.waitrequest, 1'b0);
    next_cycle();
    #1;
    chk1("t6_64_m0_wait", m0_bus.waitrequest, 1'b1);
    next_cycle();
    m0_bus.read = 1'b0;
    for (int i = 0; i < 64; i++) begin
      s_bus.readdatavalid = 1'b1;
      #1;
      chk1("t6_drain_m0_rdv", m0_bus.readdatavalid, (i != 62));
      chk1("t6_drain_m1_rdv", m1_bus.readdatavalid, (i == 62));
      next_cycle();
    end
    s_bus.readdatavalid = 1'b0;
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
